instr_fetch_resp: RTL and testbench

INSTR_FETCH_RESP -- requirements
Module: instr_fetch_resp

---
 rtl/instr_fetch_resp_if.sv | 32 +++
 rtl/instr_fetch_resp.sv | 91 +++++++++
 tb/tb_instr_fetch_resp.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/instr_fetch_resp_if.sv
// Handshake and memory bus bundle for instr_fetch_resp.
//   req_*  : fetch requests from the program-counter stage
//   mem_*  : synchronous instruction-memory read port (rdata one cycle after rd_en)
//   rsp_*  : buffered fetch responses toward the decoder
// slave  : the fetch-response unit
// master : the surrounding pipeline and memory
interface instr_fetch_resp_if;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        mem_rd_en;
   logic [31:0] mem_addr;
   logic [31:0] mem_rdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_addr;
   logic [31:0] rsp_instr;
   logic        rsp_fault;
   logic        rsp_compressed;

   modport slave (
      input  req_valid, req_addr, mem_rdata, rsp_ready,
      output req_ready, mem_rd_en, mem_addr,
             rsp_valid, rsp_addr, rsp_instr, rsp_fault, rsp_compressed
   );

   modport master (
      output req_valid, req_addr, mem_rdata, rsp_ready,
      input  req_ready, mem_rd_en, mem_addr,
             rsp_valid, rsp_addr, rsp_instr, rsp_fault, rsp_compressed
   );
endinterface

// File: rtl/instr_fetch_resp.sv
// Instruction fetch response unit: issues aligned fetches to a synchronous
// instruction memory, flags misaligned addresses as faults, and queues the
// results in a DEPTH-entry FIFO returned in request order.
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   flush : drop every in-flight and buffered fetch (redirect)
//   bus   : instr_fetch_resp_if.slave (req_*, mem_*, rsp_*)
module instr_fetch_resp #(
   parameter int unsigned DEPTH       = 4,
   parameter logic [31:0] FAULT_INSTR = 32'h0000_0000
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                flush,
   instr_fetch_resp_if.slave   bus
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic          s1_valid;
   logic [31:0]   s1_addr;
   logic          s1_fault;

   logic [CW-1:0] count;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   logic [31:0]   buf_addr  [DEPTH];
   logic [31:0]   buf_instr [DEPTH];
   logic          buf_fault [DEPTH];

   logic          clr;
   logic          accept;
   logic          aligned;
   logic          push;
   logic          pop;

   always_comb begin
      clr     = !rst_n || flush;
      // The in-flight stage-1 slot is reserved as a buffer credit, so an
      // accept can never push into a full buffer one cycle later.
      bus.req_ready = !clr && ((count + CW'(s1_valid)) < CW'(DEPTH));
      accept  = bus.req_valid && bus.req_ready;
      aligned = (bus.req_addr[1:0] == 2'b00);
      bus.mem_rd_en = accept && aligned;
      bus.mem_addr  = bus.req_addr;

      bus.rsp_valid      = (count != '0);
      bus.rsp_addr       = buf_addr[rd_ptr];
      bus.rsp_instr      = buf_instr[rd_ptr];
      bus.rsp_fault      = buf_fault[rd_ptr];
      bus.rsp_compressed = (buf_instr[rd_ptr][1:0] != 2'b11);

      // A flushed stage-1 entry never lands, so its mem_rdata is discarded.
      push = s1_valid && !clr;
      pop  = bus.rsp_valid && bus.rsp_ready;
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         s1_valid <= 1'b0;
         count    <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
      end else begin
         s1_valid <= accept;
         if (accept) begin
            s1_addr  <= bus.req_addr;
            s1_fault <= !aligned;
         end
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         buf_addr[wr_ptr]  <= s1_addr;
         buf_instr[wr_ptr] <= s1_fault ? FAULT_INSTR : bus.mem_rdata;
         buf_fault[wr_ptr] <= s1_fault;
      end
   end

   push_never_overflows: assert property (
      @(posedge clk) disable iff (!rst_n) !(push && (count == CW'(DEPTH)))
   );

endmodule

// File: tb/tb_instr_fetch_resp.sv
module tb_instr_fetch_resp;

   localparam int unsigned DEPTH       = 4;
   localparam logic [31:0] FAULT_INSTR = 32'hDEAD_0001;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic flush = 1'b0;

   always #5 clk = ~clk;

   instr_fetch_resp_if bus ();

   instr_fetch_resp #(.DEPTH(DEPTH), .FAULT_INSTR(FAULT_INSTR)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .bus   (bus)
   );

   // Reference: every accepted fetch not yet consumed, tagged with the
   // cycle it was accepted; it becomes visible two cycles later.
   typedef struct {
      logic [31:0] addr;
      int          cyc;
   } fetch_t;

   fetch_t      q[$];
   int          total = 0;
   int          bad   = 0;
   int          cyc   = 0;
   int          n_acc = 0;
   bit          chk   = 1'b0;
   logic        prev_rd   = 1'b0;
   logic [31:0] prev_addr = '0;

   function automatic logic [31:0] memf(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0000_5A5A;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic rv, input logic [31:0] a, input logic rr,
                       input logic fl, input logic rs);
      logic        exp_ready, exp_acc, exp_rd, exp_valid;
      logic [31:0] ei;
      fetch_t      e;
      @(posedge clk);
      #1;
      bus.req_valid = rv;
      bus.req_addr  = a;
      bus.rsp_ready = rr;
      flush         = fl;
      rst_n         = rs;
      bus.mem_rdata = prev_rd ? memf(prev_addr) : $urandom();
      @(negedge clk);
      exp_ready = rs && !fl && (q.size() < DEPTH);
      exp_acc   = rv && exp_ready;
      exp_rd    = exp_acc && (a[1:0] == 2'b00);
      exp_valid = (q.size() != 0) && (q[0].cyc <= cyc - 2);
      if (chk) begin
         check("req_ready", 32'(bus.req_ready), 32'(exp_ready));
         check("mem_rd_en", 32'(bus.mem_rd_en), 32'(exp_rd));
         if (exp_rd) check("mem_addr", bus.mem_addr, a);
         check("rsp_valid", 32'(bus.rsp_valid), 32'(exp_valid));
         if (exp_valid) begin
            e  = q[0];
            ei = (e.addr[1:0] != 2'b00) ? FAULT_INSTR : memf(e.addr);
            check("rsp_addr", bus.rsp_addr, e.addr);
            check("rsp_instr", bus.rsp_instr, ei);
            check("rsp_fault", 32'(bus.rsp_fault), 32'(e.addr[1:0] != 2'b00));
            check("rsp_compressed", 32'(bus.rsp_compressed), 32'(ei[1:0] != 2'b11));
         end
      end
      prev_rd   = bus.mem_rd_en;
      prev_addr = bus.mem_addr;
      if (!rs || fl) begin
         q.delete();
      end else begin
         if (exp_valid && rr) void'(q.pop_front());
         if (exp_acc) q.push_back('{addr: a, cyc: cyc});
      end
      if (exp_acc) n_acc++;
      cyc++;
   endtask

   initial begin
      int          a0;
      logic [31:0] r;
      bus.req_valid = 1'b0;
      bus.req_addr  = '0;
      bus.rsp_ready = 1'b0;
      bus.mem_rdata = '0;

      // reset
      step(0, 32'h0, 0, 0, 0);
      chk = 1'b1;
      step(0, 32'h0, 0, 0, 0);
      step(0, 32'h0, 1, 0, 1);

      // single aligned fetch
      step(1, 32'h0000_1000, 1, 0, 1);
      repeat (3) step(0, 32'h0, 1, 0, 1);

      // streaming with the consumer always ready
      a0 = n_acc;
      for (int i = 0; i < 12; i++) step(1, 32'(i * 4), 1, 0, 1);
      check("stream_accepts", 32'(n_acc - a0), 32'd12);
      repeat (3) step(0, 32'h0, 1, 0, 1);

      // backpressure: buffer fills at DEPTH, then drains in order
      a0 = n_acc;
      for (int i = 0; i < 8; i++) step(1, 32'h100 + 32'(i * 4), 0, 0, 1);
      check("backpressure_accepts", 32'(n_acc - a0), 32'(DEPTH));
      repeat (6) step(0, 32'h0, 1, 0, 1);

      // misaligned fetch faults without a memory read
      step(1, 32'h0000_1002, 1, 0, 1);
      repeat (3) step(0, 32'h0, 1, 0, 1);

      // flush with 3 buffered + 1 in flight, then a fresh request
      for (int i = 0; i < 4; i++) step(1, 32'h300 + 32'(i * 4), 0, 0, 1);
      step(1, 32'h400, 1, 1, 1);
      a0 = n_acc;
      step(1, 32'h0000_2000, 1, 0, 1);
      check("accept_after_flush", 32'(n_acc - a0), 32'd1);
      repeat (3) step(0, 32'h0, 1, 0, 1);

      // reset mid-operation with a full buffer
      for (int i = 0; i < 5; i++) step(1, 32'h500 + 32'(i * 4), 0, 0, 1);
      step(1, 32'h600, 1, 0, 0);
      a0 = n_acc;
      step(1, 32'h0000_4000, 1, 0, 1);
      check("accept_after_reset", 32'(n_acc - a0), 32'd1);
      repeat (3) step(0, 32'h0, 1, 0, 1);

      // randomized traffic
      for (int i = 0; i < 800; i++) begin
         r = $urandom();
         if ($urandom_range(0, 7) != 0) r[1:0] = 2'b00;
         step($urandom_range(0, 3) != 0, r, $urandom_range(0, 2) != 0,
              $urandom_range(0, 39) == 0, $urandom_range(0, 99) != 0);
      end
      repeat (4) step(0, 32'h0, 1, 0, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
